// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and image geometry.
package loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_HI  = 3'd0,
        S_CNT_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_WRITE   = 3'd4,
        S_CSUM    = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned DEF_AWIDTH     = 11;
    localparam int unsigned MAX_WORDS      = 2 ** DEF_AWIDTH;

    // States in which the loader is waiting for a stream byte.
    function automatic logic takes_input(state_e s);
        return s inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot loader: parses a big-endian byte-stream image, writes it into program memory,
// verifies the XOR checksum and then releases the cpu via cpu_run.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned AWIDTH = 11,
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              cpu_run,
    output logic              error
);

    localparam int unsigned MaxWords = 2 ** AWIDTH;

    state_e            state_q, state_d;
    logic [AWIDTH:0]   count_q;
    logic [7:0]        hi_q;
    logic [7:0]        csum_q;
    logic              xfer;
    logic [15:0]       n_word;

    assign xfer   = in_valid & in_ready;
    assign n_word = {hi_q, in_data};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CNT_HI:  if (xfer) state_d = S_CNT_LO;
            S_CNT_LO: begin
                if (xfer) begin
                    if (n_word == 16'd0)                state_d = S_CSUM;
                    else if (32'(n_word) > MaxWords)    state_d = S_ERR;
                    else                                state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: if (xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (xfer) state_d = S_WRITE;
            // count_q already holds the words still to come after this one
            S_WRITE:   state_d = (count_q == '0) ? S_CSUM : S_DATA_HI;
            S_CSUM:    if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            S_DONE:    state_d = S_DONE;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_CNT_HI;
            in_ready <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            cpu_run  <= 1'b0;
            error    <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            csum_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= takes_input(state_d);
            mem_wr   <= (state_d == S_WRITE);
            cpu_run  <= (state_d == S_DONE);
            error    <= (state_d == S_ERR);

            if (xfer) begin
                unique case (state_q)
                    S_CNT_HI: hi_q <= in_data;
                    S_CNT_LO: count_q <= n_word[AWIDTH:0];
                    S_DATA_HI: begin
                        hi_q   <= in_data;
                        csum_q <= csum_q ^ in_data;
                    end
                    S_DATA_LO: begin
                        mem_data <= DWIDTH'({hi_q, in_data});
                        csum_q   <= csum_q ^ in_data;
                        count_q  <= count_q - 1'b1;
                    end
                    default: ;
                endcase
            end

            // Wraps to 0 after a full-size image; that value is never written.
            if (state_q == S_WRITE) mem_addr <= mem_addr + 1'b1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader with a behavioural image model.
module tb_program_loader;

    typedef logic [7:0] u8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_wr;
    logic [10:0] mem_addr;
    logic [15:0] mem_data;
    logic        cpu_run;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    logic [10:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [10:0] mon_a;
    logic [15:0] mon_d;

    program_loader #(.AWIDTH(11), .DWIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_run  (cpu_run),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data).
    always @(negedge clk) begin
        if (rst && mem_wr) begin
            wr_count++;
            chk("ready_during_write", 32'(in_ready), 32'd0);
            if (exp_addr.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_a));
                chk("wr_data", 32'(mem_data), 32'(mon_d));
            end
        end
    end

    // Image semantics: N words at addresses 0..N-1, XOR of data bytes as checksum.
    task automatic model(input u8 img[$], output int n_acc, output bit run, output bit err,
                         output int nwr);
        int n;
        u8  cs;
        n   = int'({img[0], img[1]});
        cs  = 8'h00;
        nwr = 0;
        if (n == 0) begin
            n_acc = 3;
            run   = (img[2] == 8'h00);
        end else if (n > 2048) begin
            n_acc = 2;
            run   = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(11'(i));
                exp_data.push_back({img[2 + 2 * i], img[3 + 2 * i]});
                cs = cs ^ img[2 + 2 * i] ^ img[3 + 2 * i];
            end
            nwr   = n;
            n_acc = 2 * n + 3;
            run   = (img[2 * n + 2] == cs);
        end
        err = !run;
    endtask

    // Called at a negedge; leaves in_valid high at a negedge after the last byte.
    task automatic send_bytes(input u8 img[$], input int nbytes, input int gapmax);
        int t;
        int gap;
        for (int i = 0; i < nbytes; i++) begin
            gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = img[i];
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                chk("accept_timeout", 32'(i), 32'hFFFF_FFFF);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        wr_count = 0;
        @(negedge clk);
        rst = 1'b1;
        chk("ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    task automatic run_image(input u8 img[$], input int gapmax);
        int  n_acc;
        int  nwr;
        bit  run;
        bit  err;
        int  t;
        do_reset();
        model(img, n_acc, run, err, nwr);
        send_bytes(img, n_acc, gapmax);
        // Keep offering junk: a terminal state must never accept it.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        t = 0;
        while (!(cpu_run || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("cpu_run", 32'(cpu_run), 32'(run));
        chk("error", 32'(error), 32'(err));
        chk("ready_terminal", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("ready_held_low", 32'(in_ready), 32'd0);
        chk("write_count", 32'(wr_count), 32'(nwr));
        chk("sb_empty", 32'(exp_addr.size()), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u8   img2[$];
        u8   bad2[$];
        u8   img[$];
        u8   cs;
        int  n;
        int  d1;
        int  d2;
        bit  r;
        bit  e;
        int  nw;
        logic [15:0] w;

        img2 = {8'h00, 8'h02, 8'hA8, 8'h01, 8'h10, 8'h05, 8'hBC};
        bad2 = {8'h00, 8'h02, 8'hA8, 8'h01, 8'h10, 8'h05, 8'hB9};

        // Reset in the middle of an image, after the first word was written.
        do_reset();
        model(img2, d1, r, e, nw);
        send_bytes(img2, 4, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_writes", 32'(wr_count), 32'd1);
        do_reset();

        run_image(img2, 0);
        run_image(bad2, 0);
        run_image({8'h00, 8'h00, 8'h00}, 0);
        run_image({8'h00, 8'h00, 8'h5C}, 0);
        run_image({8'h08, 8'h01}, 0);
        for (int k = 0; k < 3; k++) run_image(img2, 3);

        for (int k = 0; k < 6; k++) begin
            n   = int'($urandom_range(0, 6));
            cs  = 8'h00;
            img = {8'h00, u8'(n)};
            for (int i = 0; i < 2 * n; i++) begin
                d2 = int'($urandom_range(0, 255));
                img.push_back(u8'(d2));
                cs = cs ^ u8'(d2);
            end
            if ($urandom_range(0, 1) == 1) cs = cs ^ u8'($urandom_range(1, 255));
            img.push_back(cs);
            run_image(img, 2);
        end

        cs  = 8'h00;
        img = {8'h08, 8'h00};
        for (int a = 0; a < 2048; a++) begin
            w = 16'(a) ^ 16'h5A5A;
            img.push_back(w[15:8]);
            img.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        img.push_back(cs);
        run_image(img, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
